// File: rtl/module_top_gray_display.sv
`default_nettype none
// ============================================================================
// Module      : module_top_gray_display
// Description : Synchronises a 4-bit Gray-code switch bus and a digit-select
//               line, converts the code to binary 0..15, splits it into BCD
//               units/tens, and drives one registered 7-segment digit.
// Revision    : 1.0 - initial release
// ============================================================================
module module_top_gray_display #(
  parameter int SYNC_STAGES = 2  // legal values: 2 or 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] gray_code,
  input  logic       show_decades,
  output logic [6:0] display_code
);

  // Each synchroniser stage carries {show_decades, gray_code} so both inputs
  // see identical delay and stay aligned.
  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic [SYNC_STAGES-1:0][4:0] sync_d;

  logic [6:0] display_q;
  logic [6:0] display_d;

  logic [3:0] gray_sync;
  logic       sel_tens;
  logic [3:0] bin_value;
  logic [3:0] units;
  logic [3:0] tens;
  logic [3:0] digit;

  // Synchroniser chain: stage 0 samples the raw pins, later stages shift.
  generate
    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync_stage
      if (i == 0) begin : g_first
        always_comb sync_d[i] = {show_decades, gray_code};
      end else begin : g_rest
        always_comb sync_d[i] = sync_q[i-1];
      end
    end
  endgenerate

  // Gray-to-binary on the last synchroniser stage, then BCD split and digit select.
  always_comb begin
    gray_sync    = sync_q[SYNC_STAGES-1][3:0];
    sel_tens     = sync_q[SYNC_STAGES-1][4];
    bin_value[3] = gray_sync[3];
    bin_value[2] = bin_value[3] ^ gray_sync[2];
    bin_value[1] = bin_value[2] ^ gray_sync[1];
    bin_value[0] = bin_value[1] ^ gray_sync[0];
    if (bin_value >= 4'd10) begin
      tens  = 4'd1;
      units = bin_value - 4'd10;
    end else begin
      tens  = 4'd0;
      units = bin_value;
    end
    digit = sel_tens ? tens : units;
  end

  // Seven-segment encoding, {g,f,e,d,c,b,a}; out-of-range digits blank.
  always_comb begin
    display_d = 7'h00;
    case (digit)
      4'd0:    display_d = 7'h3F;
      4'd1:    display_d = 7'h06;
      4'd2:    display_d = 7'h5B;
      4'd3:    display_d = 7'h4F;
      4'd4:    display_d = 7'h66;
      4'd5:    display_d = 7'h6D;
      4'd6:    display_d = 7'h7D;
      4'd7:    display_d = 7'h07;
      4'd8:    display_d = 7'h7F;
      4'd9:    display_d = 7'h6F;
      default: display_d = 7'h00;
    endcase
  end

  // State update: reset clears the synchronisers and blanks the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      display_q <= 7'h00;
    end else begin
      sync_q    <= sync_d;
      display_q <= display_d;
    end
  end

  assign display_code = display_q;

endmodule
`default_nettype wire

// File: tb/tb_module_top_gray_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_module_top_gray_display
// Description : Self-checking bench for module_top_gray_display; directed
//               scenarios plus randomized stimulus against a history-based
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_module_top_gray_display;

  localparam int S        = 2;
  localparam int MAX_EDGE = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_code;
  logic       show_decades;
  logic [6:0] display_code;

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  // Per-edge record of what the DUT sampled.
  logic [4:0] hist   [MAX_EDGE];
  logic       rst_at [MAX_EDGE];

  logic [6:0] seg [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  module_top_gray_display #(.SYNC_STAGES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .gray_code    (gray_code),
    .show_decades (show_decades),
    .display_code (display_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, k);
    end
  endtask

  // Expected output after edge e: the value sampled S edges earlier, unless a
  // reset occurred in between (then the pipeline held zero = gray 0 = "0").
  function automatic logic [6:0] model_out(input int e);
    int  g;
    int  b;
    int  d;
    logic sd;
    if (rst_at[e]) return 7'h00;
    g  = hist[e-S][3:0];
    sd = hist[e-S][4];
    for (int j = e - S; j < e; j++)
      if (rst_at[j]) begin
        g  = 0;
        sd = 1'b0;
      end
    b = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    d = sd ? b / 10 : b % 10;
    return seg[d];
  endfunction

  task automatic tick(input string tag);
    @(posedge clk);
    k++;
    rst_at[k] = rst;
    hist[k]   = {show_decades, gray_code};
    #1;
    check(tag, display_code, model_out(k));
  endtask

  task automatic hold(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    rst          = 1'b1;
    gray_code    = 4'b0000;
    show_decades = 1'b0;

    // Reset held two cycles, then release with gray 0000 / units.
    hold(2, "reset");
    check("reset_blank", display_code, 7'h00);
    rst = 1'b0;
    hold(3, "release");
    check("release_3F", display_code, 7'h3F);

    // Units sweep.
    gray_code = 4'b0001; hold(5, "sweep"); check("units_1", display_code, 7'h06);
    gray_code = 4'b0011; hold(5, "sweep"); check("units_2", display_code, 7'h5B);
    gray_code = 4'b0010; hold(5, "sweep"); check("units_3", display_code, 7'h4F);
    gray_code = 4'b0110; hold(5, "sweep"); check("units_4", display_code, 7'h66);
    gray_code = 4'b1101; hold(5, "sweep"); check("units_9", display_code, 7'h6F);

    // Two-digit values, units then tens.
    gray_code = 4'b1111; hold(5, "two"); check("u10", display_code, 7'h3F);
    gray_code = 4'b1010; hold(5, "two"); check("u12", display_code, 7'h5B);
    gray_code = 4'b1000; hold(5, "two"); check("u15", display_code, 7'h6D);
    show_decades = 1'b1;
    gray_code = 4'b1111; hold(5, "two"); check("t10", display_code, 7'h06);
    gray_code = 4'b1010; hold(5, "two"); check("t12", display_code, 7'h06);
    gray_code = 4'b1000; hold(5, "two"); check("t15", display_code, 7'h06);

    // Tens of a small value shows "0"; switching back takes 3 edges.
    gray_code = 4'b0101; hold(5, "tens6"); check("t6", display_code, 7'h3F);
    show_decades = 1'b0;
    hold(2, "sel_lat");
    check("sel_lat_e2", display_code, 7'h3F);
    tick("sel_lat");
    check("sel_lat_e3", display_code, 7'h7D);

    // Latency of a gray change.
    gray_code = 4'b0000; hold(5, "lat");
    gray_code = 4'b0001;
    tick("lat"); check("lat_N", display_code, 7'h3F);
    tick("lat"); check("lat_N1", display_code, 7'h3F);
    tick("lat"); check("lat_N2", display_code, 7'h06);

    // Mid-run reset.
    gray_code = 4'b1101; hold(5, "mid");
    check("mid_pre", display_code, 7'h6F);
    rst = 1'b1; tick("mid"); check("mid_blank", display_code, 7'h00);
    rst = 1'b0;
    hold(2, "mid");
    tick("mid"); check("mid_return", display_code, 7'h6F);

    // Fast select toggling.
    gray_code = 4'b1011;
    for (int i = 0; i < 16; i++) begin
      show_decades = ~show_decades;
      tick("toggle");
    end

    // Randomized stimulus with occasional resets.
    for (int i = 0; i < 400; i++) begin
      gray_code    = 4'($urandom_range(0, 15));
      show_decades = 1'($urandom_range(0, 1));
      rst          = ($urandom_range(0, 24) == 0);
      hold($urandom_range(1, 4), "random");
    end
    rst = 1'b0;
    hold(4, "tail");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety net against an unexpected stall.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
